// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle RV32M divider (DIV/DIVU/REM/REMU) in the execute stage.
// Consumes the ID/EX instruction and drives ready_ex back into that register.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   valid_i, inst_i      ID/EX instruction and its valid flag
//   reg1_rdata_i         dividend (rs1)
//   reg2_rdata_i         divisor (rs2)
//   reg_we_i             decoded rd write enable
//   reg_waddr_i          rd address
//   flush_i              pipeline clear; abandons any divide in flight
//   ready_ex_o           high only in IDLE; ID/EX may advance
//   busy_o               a divide is in flight (BUSY or DONE)
//   result_valid_o       one-cycle write-back strobe
//   result_o             quotient or remainder (registered, held)
//   reg_we_o             result_valid_o AND the latched write enable
//   reg_waddr_o          latched rd (registered, held)

module ex_div_unit #(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] reg1_rdata_i,
    input  logic [XLEN-1:0] reg2_rdata_i,
    input  logic            reg_we_i,
    input  logic [4:0]      reg_waddr_i,
    input  logic            flush_i,
    output logic            ready_ex_o,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            reg_we_o,
    output logic [4:0]      reg_waddr_o
);

    localparam logic [6:0]      OPC_OP    = 7'b0110011;
    localparam logic [6:0]      F7_MULDIV = 7'b0000001;
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [4:0]      LAST_STEP = 5'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_div;
    logic       op_signed;
    logic       op_rem;

    assign opcode    = inst_i[6:0];
    assign funct3    = inst_i[14:12];
    assign funct7    = inst_i[31:25];
    assign is_div    = (opcode == OPC_OP) && (funct7 == F7_MULDIV) && funct3[2];
    // funct3[0] clear selects the signed variants, funct3[1] the remainder
    assign op_signed = ~funct3[0];
    assign op_rem    = funct3[1];

    // ------------------------------------------------------------------
    // Operand preparation at accept
    // ------------------------------------------------------------------
    logic            accept;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero_in;
    logic            ovf_in;
    logic            early_done;
    logic [XLEN-1:0] special_res;

    assign accept = (state_q == S_IDLE) & valid_i & is_div & ~flush_i;

    assign a_neg = op_signed & reg1_rdata_i[XLEN-1];
    assign b_neg = op_signed & reg2_rdata_i[XLEN-1];
    assign a_abs = a_neg ? -reg1_rdata_i : reg1_rdata_i;
    assign b_abs = b_neg ? -reg2_rdata_i : reg2_rdata_i;

    assign div_zero_in = (reg2_rdata_i == '0);
    assign ovf_in      = op_signed
                       & (reg1_rdata_i == INT_MIN)
                       & (reg2_rdata_i == ALL_ONES);
    assign early_done  = EARLY_OUT & (div_zero_in | ovf_in);

    always_comb begin
        special_res = '0;
        unique case (1'b1)
            div_zero_in: special_res = op_rem ? reg1_rdata_i : ALL_ONES;
            ovf_in:      special_res = op_rem ? '0 : INT_MIN;
            default:     special_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iteration datapath: restoring shift/subtract on magnitudes.
    // quo_q starts as |dividend| and is shifted out MSB-first while the
    // quotient bits are shifted in at the bottom.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] divisor_q;
    logic [4:0]      cnt_q;
    logic            is_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            div_zero_q;
    logic            reg_we_q;
    logic [4:0]      reg_waddr_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            fits;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] res_final;
    logic            step_en;
    logic            last_step;

    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = {1'b0, shifted} - {2'b00, divisor_q};
    // no borrow out of the subtraction means the divisor fits
    assign fits    = ~diff[XLEN+1];
    // after a successful subtract the partial remainder is below the
    // divisor, so the low XLEN bits carry the whole value either way
    assign rem_nx  = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_nx  = {quo_q[XLEN-2:0], fits};

    assign quo_fix = neg_quo_q ? -quo_nx : quo_nx;
    assign rem_fix = neg_rem_q ? -rem_nx : rem_nx;

    // A zero divisor leaves rem = |dividend|, which the sign fix-up turns
    // back into the dividend; only the quotient needs overriding.
    always_comb begin
        res_final = quo_fix;
        if (is_rem_q) begin
            res_final = rem_fix;
        end else if (div_zero_q) begin
            res_final = ALL_ONES;
        end
    end

    assign step_en   = (state_q == S_BUSY) & ~flush_i;
    assign last_step = (cnt_q == LAST_STEP);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            divisor_q   <= '0;
            is_rem_q    <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            result_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                quo_q       <= a_abs;
                rem_q       <= '0;
                divisor_q   <= b_abs;
                cnt_q       <= '0;
                is_rem_q    <= op_rem;
                neg_quo_q   <= a_neg ^ b_neg;
                neg_rem_q   <= a_neg;
                div_zero_q  <= div_zero_in;
                reg_we_q    <= reg_we_i;
                reg_waddr_q <= reg_waddr_i;
                if (early_done) begin
                    result_q <= special_res;
                end
            end else if (step_en) begin
                quo_q <= quo_nx;
                rem_q <= rem_nx;
                cnt_q <= cnt_q + 5'd1;
                if (last_step) begin
                    result_q <= res_final;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        ready_ex_o     = 1'b0;
        result_valid_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready_ex_o = 1'b1;
                if (accept) begin
                    state_d = early_done ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d        = S_IDLE;
                result_valid_o = ~flush_i;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o      = ~ready_ex_o;
    assign reg_we_o    = result_valid_o & reg_we_q;
    assign result_o    = result_q;
    assign reg_waddr_o = reg_waddr_q;

    // register-index fields of inst_i and the top carry bits of the
    // iteration are not needed by the divider
    logic unused_bits;
    assign unused_bits = ^{inst_i[24:15], inst_i[11:7],
                           diff[XLEN], shifted[XLEN]};

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: randomized scoreboard bench for ex_div_unit.
// Expected write-backs are queued at issue and checked by a monitor.

module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] reg1_rdata_i = '0;
    logic [31:0] reg2_rdata_i = '0;
    logic        reg_we_i = 1'b0;
    logic [4:0]  reg_waddr_i = '0;
    logic        flush_i = 1'b0;
    logic        ready_ex_o;
    logic        busy_o;
    logic        result_valid_o;
    logic [31:0] result_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;

    ex_div_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .valid_i        (valid_i),
        .inst_i         (inst_i),
        .reg1_rdata_i   (reg1_rdata_i),
        .reg2_rdata_i   (reg2_rdata_i),
        .reg_we_i       (reg_we_i),
        .reg_waddr_i    (reg_waddr_i),
        .flush_i        (flush_i),
        .ready_ex_o     (ready_ex_o),
        .busy_o         (busy_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .reg_we_o       (reg_we_o),
        .reg_waddr_o    (reg_waddr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        int          done;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_from = 0;
    int   busy_to = -1;
    bit   chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit is_ovf(logic [31:0] a, logic [31:0] b);
        return (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    // Reference: RISC-V M-extension semantics in plain integer arithmetic.
    function automatic logic [31:0] ref_div(logic [2:0] f3,
                                            logic [31:0] a, logic [31:0] b);
        int sa;
        int sd;
        sa = a;
        sd = b;
        case (f3)
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (is_ovf(a, b)) return 32'h8000_0000;
                return sa / sd;
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (is_ovf(a, b)) return 32'h0;
                return sa % sd;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(logic [2:0] f3,
                                      logic [31:0] a, logic [31:0] b);
        return (b == 0) || (!f3[0] && is_ovf(a, b));
    endfunction

    // Present a divide (called at a negedge) and hold it until the model
    // says the unit is idle; the accepting edge follows that cycle.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic we, input bit keep);
        int   lat;
        int   acc;
        exp_t e;
        valid_i      = 1'b1;
        inst_i       = {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
        reg1_rdata_i = a;
        reg2_rdata_i = b;
        reg_waddr_i  = rd;
        reg_we_i     = we;
        while (cyc >= busy_from && cyc <= busy_to) @(negedge clk);
        lat       = is_special(f3, a, b) ? 1 : 33;
        acc       = cyc + 1;
        busy_from = acc;
        busy_to   = acc + lat - 1;
        if (keep) begin
            e.res  = ref_div(f3, a, b);
            e.rd   = rd;
            e.we   = we;
            e.done = acc + lat - 1;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        case ($urandom % 6)
            0: v = 32'h0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = $urandom % 200;
            4: begin
                v = $urandom % 200;
                v = -v;
            end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin : rdy_chk
        logic exp_rdy;
        if (chk_on) begin
            exp_rdy = !(cyc >= busy_from && cyc <= busy_to);
            chk("ready_ex", {31'b0, ready_ex_o}, {31'b0, exp_rdy});
            chk("busy", {31'b0, busy_o}, {31'b0, !exp_rdy});
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (chk_on) begin
            if (result_valid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_wb: got result %h expected none (cycle %0d)",
                             result_o, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("result", result_o, e.res);
                    chk("waddr", {27'b0, reg_waddr_o}, {27'b0, e.rd});
                    chk("reg_we", {31'b0, reg_we_o}, {31'b0, e.we});
                    chk("done_cycle", cyc, e.done);
                end
            end else begin
                chk("reg_we_idle", {31'b0, reg_we_o}, 32'h0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] f3;
        logic [31:0] nd;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, ready_ex_o}, 32'h1);
        chk("rst_valid", {31'b0, result_valid_o}, 32'h0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_waddr", {27'b0, reg_waddr_o}, 32'h0);
        chk("rst_we", {31'b0, reg_we_o}, 32'h0);
        rst_ni = 1'b1;
        chk_on = 1'b1;
        idle(2);

        // normal divides, back to back
        issue(3'b101, 32'd100, 32'd7, 5'd5, 1'b1, 1'b1);
        issue(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd6, 1'b1, 1'b1);
        issue(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd7, 1'b1, 1'b1);
        issue(3'b111, 32'd100, 32'd7, 5'd8, 1'b1, 1'b1);
        idle(40);
        chk("hold_result", result_o, 32'd2);
        chk("hold_waddr", {27'b0, reg_waddr_o}, 32'd8);

        // early-out special cases
        issue(3'b100, 32'h1234, 32'h0, 5'd9, 1'b1, 1'b1);
        issue(3'b111, 32'h1234, 32'h0, 5'd10, 1'b1, 1'b1);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 1'b1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1, 1'b1);
        idle(3);

        // rd = x0 still writes back; we=0 suppresses reg_we_o
        issue(3'b100, 32'd1000, 32'hFFFF_FFFD, 5'd0, 1'b1, 1'b1);
        issue(3'b101, 32'd50, 32'd3, 5'd13, 1'b0, 1'b1);
        idle(40);

        // flush in IDLE blocks accept
        valid_i = 1'b1;
        inst_i  = {7'b0000001, 5'd2, 5'd1, 3'b101, 5'd3, 7'b0110011};
        reg1_rdata_i = 32'd77;
        reg2_rdata_i = 32'd5;
        flush_i = 1'b1;
        repeat (3) @(negedge clk);
        flush_i = 1'b0;
        idle(3);

        // flush in cycle 10 of a divide
        issue(3'b101, 32'd1000, 32'd3, 5'd14, 1'b1, 1'b0);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        busy_to = cyc;
        @(negedge clk);
        flush_i = 1'b0;
        idle(40);

        // reset in cycle 5 of a divide
        issue(3'b100, 32'h7777, 32'd5, 5'd15, 1'b1, 1'b0);
        valid_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_ni  = 1'b0;
        busy_to = cyc;
        @(negedge clk);
        rst_ni = 1'b1;
        chk("mid_rst_result", result_o, 32'h0);
        chk("mid_rst_waddr", {27'b0, reg_waddr_o}, 32'h0);
        chk("mid_rst_valid", {31'b0, result_valid_o}, 32'h0);
        chk("mid_rst_we", {31'b0, reg_we_o}, 32'h0);
        idle(40);

        // non-divide instructions are ignored
        for (int i = 0; i < 20; i++) begin
            valid_i = 1'b1;
            case ($urandom % 3)
                0: inst_i = {7'b0000001, 5'd2, 5'd1, 3'($urandom % 4),
                             5'd4, 7'b0110011};
                1: inst_i = {7'b0000000, 5'd2, 5'd1, 3'($urandom % 8),
                             5'd4, 7'b0110011};
                default: inst_i = {7'b0000001, 5'd2, 5'd1, 3'b100,
                                   5'd4, 7'b0010011};
            endcase
            reg1_rdata_i = $urandom;
            reg2_rdata_i = $urandom;
            @(negedge clk);
        end
        idle(2);

        // randomized divides
        for (int i = 0; i < 40; i++) begin
            if ($urandom % 3 == 0) idle($urandom % 4);
            f3 = 3'(4 + ($urandom % 4));
            nd = rnd_op();
            issue(f3, rnd_op(), nd, 5'($urandom % 32), 1'($urandom % 2),
                  1'b1);
        end
        idle(1);
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        chk("sb_drained", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
